// File: rtl/t_serial_adder_pkg.sv
// Shared ternary definitions for the trit-serial adder: trit encodings,
// controller states and the illegal-trit sanitiser.
package t_pkg;

    localparam logic [1:0] T_ZERO    = 2'b00;
    localparam logic [1:0] T_ONE     = 2'b01;
    localparam logic [1:0] T_TWO     = 2'b10;
    localparam logic [1:0] T_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [1:0] trit_sanitize(input logic [1:0] t);
        return (t == T_ILLEGAL) ? T_ZERO : t;
    endfunction

endpackage

// File: rtl/t_serial_adder_full_adder.sv
// Single-trit ternary full adder: sum is a chain of two mod-3 xor gates,
// carry is a threshold on the three-input total (a + b + c >= 3).
module t_mod3_xor (
    input  logic [1:0] x_i,
    input  logic [1:0] y_i,
    output logic [1:0] z_o
);
    logic [2:0] tot;
    logic [2:0] red;

    assign tot = {1'b0, x_i} + {1'b0, y_i};
    assign red = tot - 3'd3;
    assign z_o = (tot >= 3'd3) ? red[1:0] : tot[1:0];
endmodule

module t_full_adder
    import t_pkg::*;
(
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    input  logic [1:0] cin_i,
    output logic [1:0] sum_o,
    output logic [1:0] carry_o
);
    logic [1:0] ab;
    logic [2:0] tot;

    t_mod3_xor u_xor_ab (.x_i(a_i), .y_i(b_i),   .z_o(ab));
    t_mod3_xor u_xor_c  (.x_i(ab),  .y_i(cin_i), .z_o(sum_o));

    // Operands are already sanitised and carry is 0/1, so tot spans 0..5.
    assign tot     = {1'b0, a_i} + {1'b0, b_i} + {1'b0, cin_i};
    assign carry_o = (tot >= 3'd3) ? T_ONE : T_ZERO;
endmodule

// File: rtl/t_serial_adder.sv
// Trit-serial unsigned ternary adder: accepts two N-trit words plus carry,
// adds one trit per clock LSB-first, and presents sum/carry-out on a handshake.
module t_serial_adder
    import t_pkg::*;
#(
    parameter int N_TRITS = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*N_TRITS-1:0] a,
    input  logic [2*N_TRITS-1:0] b,
    input  logic [1:0]           cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*N_TRITS-1:0] sum,
    output logic [1:0]           cout,
    output logic                 err
);
    localparam int W  = 2 * N_TRITS;
    localparam int CW = $clog2(N_TRITS + 1);
    localparam logic [CW-1:0] LAST = CW'(N_TRITS - 1);

    state_t        state_q;
    logic          in_ready_q, out_valid_q, err_q;
    logic [W-1:0]  a_q, b_q, sum_q;
    logic [1:0]    carry_q, cout_q;
    logic [CW-1:0] cnt_q;

    logic [W-1:0]  a_san, b_san, sum_d;
    logic [W+1:0]  sum_ext;
    logic          acc_err;
    logic [1:0]    fa_sum, fa_carry;

    // Illegal trits are zeroed before they reach the shift registers.
    always_comb begin
        a_san   = '0;
        b_san   = '0;
        acc_err = cin[1];
        for (int i = 0; i < N_TRITS; i++) begin
            a_san[2*i +: 2] = trit_sanitize(a[2*i +: 2]);
            b_san[2*i +: 2] = trit_sanitize(b[2*i +: 2]);
            if (a[2*i +: 2] == T_ILLEGAL || b[2*i +: 2] == T_ILLEGAL)
                acc_err = 1'b1;
        end
    end

    t_full_adder u_fa (
        .a_i    (a_q[1:0]),
        .b_i    (b_q[1:0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .carry_o(fa_carry)
    );

    // New sum trit enters at the MSB; after N_TRITS shifts trit 0 sits at bit 0.
    assign sum_ext = {fa_sum, sum_q};
    assign sum_d   = sum_ext[W+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= T_ZERO;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            carry_q     <= T_ZERO;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q        <= a_san;
                    b_q        <= b_san;
                    carry_q    <= cin[1] ? T_ZERO : cin;
                    err_q      <= acc_err;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b0;
                    state_q    <= RUN;
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= fa_carry;
                    a_q     <= a_q >> 2;
                    b_q     <= b_q >> 2;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        cout_q      <= fa_carry;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err       = err_q;
endmodule

// File: tb/tb_t_serial_adder.sv
// Scoreboard bench: a 3-trit instance runs directed cases, a 9-trit instance
// runs back-to-back random legal words against an integer model.
module tb_t_serial_adder;

    typedef struct packed {
        logic [17:0] s;
        logic [1:0]  c;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic        rst3, iv3, ir3, ov3, or3, err3;
    logic [5:0]  a3, b3, sum3;
    logic [1:0]  cin3, cout3;
    logic        rst9, iv9, ir9, ov9, or9, err9;
    logic [17:0] a9, b9, sum9;
    logic [1:0]  cin9, cout9;

    exp_t q3[$];
    exp_t q9[$];

    t_serial_adder #(.N_TRITS(3)) u3 (
        .clk(clk), .rst(rst3), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
        .cin(cin3), .out_valid(ov3), .out_ready(or3), .sum(sum3), .cout(cout3), .err(err3)
    );

    t_serial_adder u9 (
        .clk(clk), .rst(rst9), .in_valid(iv9), .in_ready(ir9), .a(a9), .b(b9),
        .cin(cin9), .out_valid(ov9), .out_ready(or9), .sum(sum9), .cout(cout9), .err(err9)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin : mon3
        exp_t e;
        if (!rst3 && ov3 && or3) begin
            if (q3.size() == 0) chk("d3 unexpected result", 64'(q3.size()), 64'd1);
            else begin
                e = q3.pop_front();
                chk("d3 sum",  64'(sum3),  64'(e.s));
                chk("d3 cout", 64'(cout3), 64'(e.c));
                chk("d3 err",  64'(err3),  64'(e.e));
            end
        end
    end

    always @(negedge clk) begin : mon9
        exp_t e;
        if (!rst9 && ov9 && or9) begin
            if (q9.size() == 0) chk("d9 unexpected result", 64'(q9.size()), 64'd1);
            else begin
                e = q9.pop_front();
                chk("d9 sum",  64'(sum9),  64'(e.s));
                chk("d9 cout", 64'(cout9), 64'(e.c));
                chk("d9 err",  64'(err9),  64'(e.e));
            end
        end
    end

    // All driving tasks start and end just after a rising edge.
    task automatic send3(input logic [5:0] a, input logic [5:0] b, input logic [1:0] c,
                         input bit push, input exp_t e);
        int g = 0;
        bit rdy = 0;
        a3 = a; b3 = b; cin3 = c; iv3 = 1'b1;
        if (push) q3.push_back(e);
        while (!rdy && g < 50) begin
            @(negedge clk); rdy = ir3;
            @(posedge clk); g++;
        end
        #1 iv3 = 1'b0;
        if (!rdy) chk("d3 accept timeout", 64'(rdy), 64'd1);
    endtask

    task automatic send9(input logic [17:0] a, input logic [17:0] b, input logic [1:0] c,
                         input exp_t e);
        int g = 0;
        bit rdy = 0;
        a9 = a; b9 = b; cin9 = c; iv9 = 1'b1;
        q9.push_back(e);
        while (!rdy && g < 50) begin
            @(negedge clk); rdy = ir9;
            @(posedge clk); g++;
        end
        #1 iv9 = 1'b0;
        if (!rdy) chk("d9 accept timeout", 64'(rdy), 64'd1);
    endtask

    task automatic wait_done3();
        int g = 0;
        while ((q3.size() != 0 || !ir3) && g < 100) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 100) chk("d3 completion timeout", 64'(g), 64'd0);
    endtask

    task automatic wait_done9();
        int g = 0;
        while ((q9.size() != 0 || !ir9) && g < 100) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 100) chk("d9 completion timeout", 64'(g), 64'd0);
    endtask

    function automatic logic [17:0] enc9(input int v);
        logic [17:0] r = '0;
        int x = v;
        for (int i = 0; i < 9; i++) begin
            r[2*i +: 2] = 2'(x % 3);
            x = x / 3;
        end
        return r;
    endfunction

    initial begin
        int lowcnt, fv, g, prev, acc, va, vb, vc, tot;
        bit seen_hi;
        rst3 = 1; rst9 = 1; iv3 = 0; iv9 = 0; or3 = 1; or9 = 1;
        a3 = '0; b3 = '0; cin3 = '0; a9 = '0; b9 = '0; cin9 = '0;
        repeat (2) @(posedge clk);
        #1 rst3 = 0; rst9 = 0;

        @(negedge clk);
        chk("reset in_ready",  64'(ir3),   64'd1);
        chk("reset out_valid", 64'(ov3),   64'd0);
        chk("reset sum",       64'(sum3),  64'd0);
        chk("reset cout",      64'(cout3), 64'd0);
        chk("reset err",       64'(err3),  64'd0);
        chk("reset9 in_ready", 64'(ir9),   64'd1);
        chk("reset9 out_valid",64'(ov9),   64'd0);
        @(posedge clk); #1;

        // 5 + 4 + 0 = 9 -> 100 in ternary
        send3(6'b00_01_10, 6'b00_01_01, 2'b00, 1, '{s: 18'b01_00_00, c: 2'b00, e: 1'b0});
        lowcnt = 0; fv = -1; seen_hi = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ir3) seen_hi = 1;
            else if (!seen_hi) lowcnt++;
            if (ov3 && fv < 0) fv = i;
        end
        chk("basic in_ready low cycles", 64'(lowcnt), 64'd4);
        chk("basic out_valid latency",   64'(fv),     64'd3);
        @(posedge clk); #1;
        wait_done3();

        // 26 + 26 + 1 = 53 = 27 + 26
        send3(6'b10_10_10, 6'b10_10_10, 2'b01, 1, '{s: 18'b10_10_10, c: 2'b01, e: 1'b0});
        wait_done3();

        // Backpressure: 1+1 held in DONE while a second word is pulsed.
        or3 = 0;
        send3(6'b00_00_01, 6'b00_00_01, 2'b00, 1, '{s: 18'b00_00_10, c: 2'b00, e: 1'b0});
        g = 0;
        while (!ov3 && g < 50) begin @(negedge clk); g++; end
        chk("bp out_valid seen", 64'(ov3), 64'd1);
        @(posedge clk); #1;
        a3 = 6'b00_00_10; b3 = 6'b00_00_00; cin3 = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp sum hold",  64'(sum3),  64'b00_00_10);
            chk("bp cout hold", 64'(cout3), 64'd0);
            chk("bp err hold",  64'(err3),  64'd0);
            chk("bp in_ready",  64'(ir3),   64'd0);
            chk("bp out_valid", 64'(ov3),   64'd1);
            @(posedge clk); #1 iv3 = ~iv3;
        end
        iv3 = 1; or3 = 1;
        q3.push_back('{s: 18'b00_01_00, c: 2'b00, e: 1'b0});
        @(posedge clk);
        @(negedge clk);
        chk("bp release out_valid", 64'(ov3), 64'd0);
        chk("bp release in_ready",  64'(ir3), 64'd1);
        @(posedge clk); #1 iv3 = 0;
        @(negedge clk);
        chk("bp new word accepted", 64'(ir3), 64'd0);
        @(posedge clk); #1;
        wait_done3();

        // Illegal trit in a and illegal cin both squashed to zero.
        send3(6'b00_00_11, 6'b00_00_00, 2'b10, 1, '{s: 18'd0, c: 2'b00, e: 1'b1});
        wait_done3();
        send3(6'b00_00_01, 6'b00_00_01, 2'b00, 1, '{s: 18'b00_00_10, c: 2'b00, e: 1'b0});
        wait_done3();

        // Reset after one trit has been processed.
        send3(6'b00_00_01, 6'b00_00_01, 2'b00, 0, '{s: 18'd0, c: 2'b00, e: 1'b0});
        @(posedge clk); #1 rst3 = 1;
        @(posedge clk); #1 rst3 = 0;
        @(negedge clk);
        chk("midrst in_ready",  64'(ir3),   64'd1);
        chk("midrst out_valid", 64'(ov3),   64'd0);
        chk("midrst sum",       64'(sum3),  64'd0);
        chk("midrst cout",      64'(cout3), 64'd0);
        @(posedge clk); #1;
        send3(6'b00_00_01, 6'b00_00_01, 2'b00, 1, '{s: 18'b00_00_10, c: 2'b00, e: 1'b0});
        wait_done3();

        // 9-trit back-to-back; first word is the maximum-carry corner.
        prev = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 0) begin va = 19682; vb = 19682; vc = 1; end
            else begin
                va = int'($urandom_range(0, 19682));
                vb = int'($urandom_range(0, 19682));
                vc = int'($urandom_range(0, 1));
            end
            tot = va + vb + vc;
            send9(enc9(va), enc9(vb), 2'(vc),
                  '{s: enc9(tot % 19683), c: 2'(tot / 19683), e: 1'b0});
            acc = cyc;
            if (k > 0) chk("d9 accept spacing", 64'(acc - prev), 64'd11);
            prev = acc;
        end
        wait_done9();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
